// File: rtl/sequential_divider.sv
// Signed restoring divider, one quotient bit per clock.
// Truncating division with hex display outputs.
module sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load_divisor,
    input  logic             Execute,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic [WIDTH-1:0] Divisor_val,
    output logic             Busy,
    output logic             Done,
    output logic             Div_zero,
    output logic             Overflow,
    output logic [6:0]       QhexU,
    output logic [6:0]       QhexL,
    output logic [6:0]       RhexU,
    output logic [6:0]       RhexL
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_n;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] div, q, d, r, dvd;
    logic             sign_q, sign_r, dz_p, ov_p;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH:0]   t;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic; DONE waits for Execute release
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (Execute) state_n = ITER;
            ITER: if (count == LAST) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: if (!Execute) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Shifted partial remainder and trial subtraction
    always_comb begin
        r_sh = {r[WIDTH-2:0], q[WIDTH-1]};
        t    = {1'b0, r_sh} - {1'b0, d};
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count     <= '0;
            div       <= '0;
            q         <= '0;
            d         <= '0;
            r         <= '0;
            dvd       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            dz_p      <= 1'b0;
            ov_p      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Div_zero  <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Execute) begin
                        q      <= mag(Din);
                        d      <= mag(div);
                        r      <= '0;
                        dvd    <= Din;
                        count  <= '0;
                        sign_q <= Din[WIDTH-1] ^ div[WIDTH-1];
                        sign_r <= Din[WIDTH-1];
                        dz_p   <= (div == '0);
                        ov_p   <= (Din == MIN) && (div == '1);
                    end else if (Load_divisor) begin
                        div <= Din;
                    end
                end
                ITER: begin
                    r     <= t[WIDTH] ? r_sh : t[WIDTH-1:0];
                    q     <= {q[WIDTH-2:0], ~t[WIDTH]};
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (dz_p) begin
                        Quotient  <= '1;
                        Remainder <= dvd;
                        Div_zero  <= 1'b1;
                        Overflow  <= 1'b0;
                    end else if (ov_p) begin
                        Quotient  <= MIN;
                        Remainder <= '0;
                        Div_zero  <= 1'b0;
                        Overflow  <= 1'b1;
                    end else begin
                        Quotient  <= sign_q ? (~q + 1'b1) : q;
                        Remainder <= sign_r ? (~r + 1'b1) : r;
                        Div_zero  <= 1'b0;
                        Overflow  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and display decode
    always_comb begin
        Busy        = (state == ITER) || (state == FIX);
        Done        = (state == DONE);
        Divisor_val = div;
        QhexU       = seg(Quotient[7:4]);
        QhexL       = seg(Quotient[3:0]);
        RhexU       = seg(Remainder[7:4]);
        RhexL       = seg(Remainder[3:0]);
    end

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider.
// Directed and random operations against an arithmetic model.
module tb_sequential_divider;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Din;
    logic       Load_divisor;
    logic       Execute;
    logic [7:0] Quotient, Remainder, Divisor_val;
    logic       Busy, Done, Div_zero, Overflow;
    logic [6:0] QhexU, QhexL, RhexU, RhexL;

    int checks   = 0;
    int failures = 0;
    logic [7:0] div_model = 8'h00;
    logic [7:0] prev_q    = 8'h00;

    sequential_divider #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Din(Din),
        .Load_divisor(Load_divisor), .Execute(Execute),
        .Quotient(Quotient), .Remainder(Remainder),
        .Divisor_val(Divisor_val), .Busy(Busy), .Done(Done),
        .Div_zero(Div_zero), .Overflow(Overflow),
        .QhexU(QhexU), .QhexL(QhexL), .RhexU(RhexU), .RhexL(RhexL)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] tbl [16] = '{
            7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[n];
    endfunction

    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output bit dz, output bit ov);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 0;
        ov = 0;
        if (sb == 0) begin
            q = 8'hFF; r = a; dz = 1;
        end else if (sa == -128 && sb == -1) begin
            q = 8'h80; r = 8'h00; ov = 1;
        end else begin
            q = 8'(sa / sb);
            r = 8'(sa % sb);
        end
    endtask

    task automatic load_div(input logic [7:0] v);
        @(negedge Clk);
        Din = v;
        Load_divisor = 1'b1;
        @(negedge Clk);
        Load_divisor = 1'b0;
        div_model = v;
        check("divisor_load", Divisor_val, v);
    endtask

    task automatic run_op(input logic [7:0] dv, input int hold,
                          input bit pulse);
        int n;
        logic [7:0] eq, er;
        bit edz, eov;
        model(dv, div_model, eq, er, edz, eov);
        @(negedge Clk);
        Din = dv;
        Execute = 1'b1;
        n = 0;
        while (!Done && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
            if (n == 5) begin
                check("busy_mid", Busy, 1);
                check("q_hold_mid", Quotient, prev_q);
                if (pulse) begin
                    Load_divisor = 1'b1;
                    Din = ~dv;
                end
            end
        end
        Load_divisor = 1'b0;
        check("latency", n, 10);
        check("quotient", Quotient, eq);
        check("remainder", Remainder, er);
        check("div_zero", Div_zero, edz);
        check("overflow", Overflow, eov);
        check("divisor_keep", Divisor_val, div_model);
        check("hex", {QhexU, QhexL, RhexU, RhexL},
              {seg7(eq[7:4]), seg7(eq[3:0]), seg7(er[7:4]), seg7(er[3:0])});
        if (hold > 0) begin
            repeat (hold) @(posedge Clk);
            #1;
            check("done_held", Done, 1);
            check("busy_held", Busy, 0);
            check("q_held", Quotient, eq);
        end
        @(negedge Clk);
        Execute = 1'b0;
        @(posedge Clk);
        #1;
        check("done_release", Done, 0);
        check("idle_release", Busy, 0);
        prev_q = eq;
    endtask

    initial begin
        Reset = 1'b0;
        Din = 8'h00;
        Load_divisor = 1'b0;
        Execute = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_outs", {Quotient, Remainder, Divisor_val}, 24'h0);
        check("rst_flags", {Busy, Done, Div_zero, Overflow}, 4'h0);
        @(negedge Clk);
        Reset = 1'b1;

        load_div(8'h07);
        run_op(8'h64, 0, 0);
        run_op(8'h9C, 0, 0);
        load_div(8'hF9);
        run_op(8'h64, 0, 0);
        load_div(8'h00);
        run_op(8'h05, 0, 0);
        load_div(8'hFF);
        run_op(8'h80, 0, 0);
        load_div(8'h07);
        run_op(8'h64, 0, 0);
        run_op(8'h80, 30, 0);
        run_op(8'h3B, 0, 1);

        load_div(8'h07);
        @(negedge Clk);
        Din = 8'h64;
        Execute = 1'b1;
        repeat (5) @(posedge Clk);
        #2;
        check("busy_before_rst", Busy, 1);
        Reset = 1'b0;
        #1;
        check("arst_outs", {Quotient, Remainder, Divisor_val}, 24'h0);
        check("arst_flags", {Busy, Done, Div_zero, Overflow}, 4'h0);
        Execute = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        div_model = 8'h00;
        prev_q = 8'h00;
        load_div(8'h07);
        run_op(8'h64, 0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i % 8 == 3) b = 8'h00;
            if (i % 8 == 5) b = 8'hFF;
            load_div(b);
            run_op((i % 8 == 5) ? 8'h80 : 8'($urandom), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
